param_register: RTL
===================

# param_register

Parametrised general-purpose register for the basic-computer datapath: the successor to the fixed 16-bit load/inc/clr register. It adds:
- configurable width and reset value;
- decrement, logical shift left/right with serial input;
- a carry/link bit (E-style);
- zero flag, wrap-around pulse and optional saturating count mode.

It is instantiated for AC, PC, AR, DR, TR and SC.

## Interface
Parameters
- WIDTH, 16, data width in bits (≥2)
- RESET_VALUE, 0, outdata value after rst (WIDTH bits)
- SATURATE, 0, 1 = inc/dec clamp at max/0 instead of wrapping

Ports
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- clr  in  1  clear outdata and carry
- load  in  1  load indata
- inc  in  1  increment
- dec  in  1  decrement
- shl  in  1  shift left, ser_in into bit 0
- shr  in  1  shift right, ser_in into bit WIDTH-1
- ser_in  in  1  serial input bit for shifts
- indata  in  WIDTH  parallel load data
- outdata  out  WIDTH  register contents
- carry  out  1  carry/borrow/shifted-out bit (registered)
- zero  out  1  outdata == 0 (combinational from outdata)
- wrap  out  1  one-cycle registered pulse on inc/dec wrap-around

## Operation
- Fixed priority per cycle: rst > clr > load > inc > dec > shl > shr > hold. Exactly one operation executes; lower-priority requests in the same cycle are ignored, not queued.
- rst: outdata=RESET_VALUE, carry=0, wrap=0.
- clr: outdata=0, carry=0, wrap=0.
- load: outdata=indata; carry unchanged; wrap=0.
- inc, SATURATE=0: {carry,outdata} = outdata+1 in WIDTH+1-bit arithmetic. wrap=1 when old outdata = 2^WIDTH-1 (result 0, carry=1); else carry=0.
- inc, SATURATE=1: at max, outdata holds max, carry=1, wrap=0. Otherwise as above with carry=0.
- dec, SATURATE=0: outdata = outdata-1 mod 2^WIDTH. carry = borrow, i.e. 1 iff old outdata = 0; wrap=1 in that case.
- dec, SATURATE=1: at 0, outdata holds 0, carry=1, wrap=0.
- shl: outdata = {outdata[WIDTH-2:0], ser_in}, carry = old outdata[WIDTH-1], wrap=0.
- shr: outdata = {ser_in, outdata[WIDTH-1:1]}, carry = old outdata[0], wrap=0.
- hold (no request): outdata, carry unchanged; wrap=0.
- zero follows outdata with no register delay.

## Timing
- Latency 1: a request sampled at rising edge N appears on outdata/carry/wrap after edge N.
- Control and data inputs must be stable around the rising edge. Benches drive them on the falling edge and check one half-period after the next rising edge.
- wrap is high for exactly one cycle after the wrapping edge. Back-to-back wrapping ops produce back-to-back pulses; non-wrapping ops drop wrap to 0.
- rst asserted mid-sequence (e.g. during a run of inc) overrides everything at that edge. There is no residual state; the operation resumes from RESET_VALUE on the first edge after rst deasserts.
- Reset values: outdata=RESET_VALUE, carry=0, wrap=0, zero=(RESET_VALUE==0).

## Structure
- Shared package basc_pkg holds:
  - operation select encoding: OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR;
  - default width constant BASC_WORD=16.
- Sub-module param_register_next (combinational):
  - takes the priority-encoded op, outdata, carry, indata and ser_in;
  - returns next outdata, next carry and next wrap;
  - top level holds the priority encoder plus flops only.
- Verification reuses the existing random-command style: drive on the falling edge, check after the rising edge against a reference model.

## Test plan
- WIDTH=16: rst with RESET_VALUE=16'h0100 -> outdata=0100, carry=0, zero=0, wrap=0. Then clr -> outdata=0000, zero=1.
- WIDTH=16: load FFFF, then inc -> outdata=0000, carry=1, wrap=1 for one cycle. A further inc -> 0001, carry=0, wrap=0. Then dec, dec -> FFFF, carry=1, wrap=1.
- WIDTH=8, SATURATE=1: load FE, inc, inc -> FF then FF, carry=1, wrap=0. Then load 01, dec, dec -> 00 then 00, carry=1.
- WIDTH=16: load 8001, shl with ser_in=1 -> 0003, carry=1. Then shr with ser_in=0 -> 0001, carry=1.
- Priority: load=1, inc=1, clr=1 with indata=1234 -> outdata=0000. Next cycle load=1, inc=1, dec=1 -> 1234. Next cycle inc=1, dec=1 -> 1235.
- Reset mid-run: inc held high from 0 for 5 cycles, rst pulsed on cycle 3 -> sequence 1,2,RESET_VALUE,RESET_VALUE+1,…. Follow with 30000 ns of random ops checked against the model, for WIDTH in {8,16}.

Source files
------------

// File: rtl/basc_pkg.sv
// Shared definitions for the basic-computer register family:
// the priority-encoded operation select and the default word width.
package basc_pkg;

  localparam int BASC_WORD = 16;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6
  } op_e;

endpackage

// File: rtl/param_register_next.sv
// Next-state datapath for param_register: given one already-arbitrated
// operation, computes the next register contents, carry/link bit and wrap pulse.
module param_register_next
  import basc_pkg::*;
#(
  parameter int WIDTH    = BASC_WORD,
  parameter int SATURATE = 0
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] cur_data,
  input  logic             cur_carry,
  input  logic [WIDTH-1:0] indata,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_data,
  output logic             next_carry,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max_s;
  logic at_zero_s;

  assign at_max_s  = (cur_data == ALL_ONES);
  assign at_zero_s = (cur_data == ALL_ZEROS);

  // Operation decode; boundary inc/dec either wrap with a pulse or clamp.
  always_comb begin
    next_data  = cur_data;
    next_carry = cur_carry;
    next_wrap  = 1'b0;
    case (op)
      OP_CLR: begin
        next_data  = ALL_ZEROS;
        next_carry = 1'b0;
      end
      OP_LOAD: begin
        next_data = indata;
      end
      OP_INC: begin
        if (at_max_s) begin
          next_carry = 1'b1;
          if (SATURATE != 0) begin
            next_data = ALL_ONES;
          end else begin
            next_data = ALL_ZEROS;
            next_wrap = 1'b1;
          end
        end else begin
          next_data  = cur_data + ONE;
          next_carry = 1'b0;
        end
      end
      OP_DEC: begin
        if (at_zero_s) begin
          next_carry = 1'b1;
          if (SATURATE != 0) begin
            next_data = ALL_ZEROS;
          end else begin
            next_data = ALL_ONES;
            next_wrap = 1'b1;
          end
        end else begin
          next_data  = cur_data - ONE;
          next_carry = 1'b0;
        end
      end
      OP_SHL: begin
        next_data  = {cur_data[WIDTH-2:0], ser_in};
        next_carry = cur_data[WIDTH-1];
      end
      OP_SHR: begin
        next_data  = {ser_in, cur_data[WIDTH-1:1]};
        next_carry = cur_data[0];
      end
      default: begin
        next_data  = cur_data;
        next_carry = cur_carry;
      end
    endcase
  end

endmodule

// File: rtl/param_register.sv
// Parametrised datapath register (AC/PC/AR/DR/TR/SC): fixed-priority request
// encoder plus state flops; the arithmetic lives in param_register_next.
module param_register
  import basc_pkg::*;
#(
  parameter int               WIDTH       = BASC_WORD,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               SATURATE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] outdata,
  output logic             carry,
  output logic             zero,
  output logic             wrap
);

  op_e              op_s;
  logic [WIDTH-1:0] outdata_d;
  logic [WIDTH-1:0] outdata_q;
  logic             carry_d;
  logic             carry_q;
  logic             wrap_d;
  logic             wrap_q;

  // Request arbitration: lower-priority requests are dropped, not queued.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (inc) begin
      op_s = OP_INC;
    end else if (dec) begin
      op_s = OP_DEC;
    end else if (shl) begin
      op_s = OP_SHL;
    end else if (shr) begin
      op_s = OP_SHR;
    end else begin
      op_s = OP_HOLD;
    end
  end

  param_register_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .op         (op_s),
    .cur_data   (outdata_q),
    .cur_carry  (carry_q),
    .indata     (indata),
    .ser_in     (ser_in),
    .next_data  (outdata_d),
    .next_carry (carry_d),
    .next_wrap  (wrap_d)
  );

  // State flops; rst overrides every request at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      outdata_q <= RESET_VALUE;
      carry_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      outdata_q <= outdata_d;
      carry_q   <= carry_d;
      wrap_q    <= wrap_d;
    end
  end

  assign outdata = outdata_q;
  assign carry   = carry_q;
  assign wrap    = wrap_q;
  assign zero    = (outdata_q == {WIDTH{1'b0}});

endmodule
